// File: rtl/uart_echo_responder.sv
// Far-end 8N1 UART peer: receives bytes on an oversampled RX path, buffers them
// in a 4-deep FIFO and retransmits each byte unchanged on its serial output.
module uart_echo_responder #(
  parameter int unsigned clocks_per_bit = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       tx_hold,
  output logic       out,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       overflow,
  output logic       tx_active,
  output logic       tx_done,
  output logic [2:0] fifo_count
);

  localparam int unsigned CNT_W      = $clog2(clocks_per_bit);
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(clocks_per_bit - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((clocks_per_bit - 1) / 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             in_meta, in_s;
  logic [1:0]       rx_state, rx_state_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             rx_good_c, rx_bad_c;

  logic [1:0]       tx_state, tx_state_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shift;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [1:0]       wr_ptr, rd_ptr;
  logic             push_c, pop_c;

  // Two-flop synchronizer; resets to the idle line level
  always_ff @(posedge clk) begin
    if (rst) begin
      in_meta <= 1'b1;
      in_s    <= 1'b1;
    end else begin
      in_meta <= in;
      in_s    <= in_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state;
    rx_good_c     = 1'b0;
    rx_bad_c      = 1'b0;
    case (rx_state)
      S_IDLE:  if (!in_s) rx_state_next = S_START;
      S_START: if (rx_cnt == HALF_BIT) rx_state_next = in_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_cnt == BIT_LAST && rx_idx == 3'd7) rx_state_next = S_STOP;
      S_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_next = S_IDLE;
          rx_good_c     = in_s;
          rx_bad_c      = !in_s;
        end
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= rx_good_c;
      frame_err <= rx_bad_c;
      if (rx_good_c) rx_byte <= rx_shift;
      case (rx_state)
        S_IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
        end
        S_START: rx_cnt <= (rx_cnt == HALF_BIT) ? '0 : rx_cnt + CNT_W'(1);
        S_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= rx_idx + 3'd1;
            rx_shift <= {in_s, rx_shift[7:1]};
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        S_STOP:  rx_cnt <= (rx_cnt == BIT_LAST) ? '0 : rx_cnt + CNT_W'(1);
        default: rx_cnt <= '0;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign pop_c  = (tx_state == S_IDLE) && (fifo_count != 3'd0) && !tx_hold;
  assign push_c = rx_good_c && ((fifo_count != 3'(FIFO_DEPTH)) || pop_c);

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= rx_good_c && !push_c;
      if (push_c) wr_ptr <= wr_ptr + 2'd1;
      if (pop_c)  rd_ptr <= rd_ptr + 2'd1;
      case ({push_c, pop_c})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state;
    case (tx_state)
      S_IDLE:  if (pop_c) tx_state_next = S_START;
      S_START: if (tx_cnt == BIT_LAST) tx_state_next = S_DATA;
      S_DATA:  if (tx_cnt == BIT_LAST && tx_idx == 3'd7) tx_state_next = S_STOP;
      S_STOP:  if (tx_cnt == BIT_LAST) tx_state_next = S_IDLE;
      default: tx_state_next = S_IDLE;
    endcase
  end

  // Line outputs trail the TX state by one register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      out       <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_active <= (tx_state != S_IDLE);
      tx_done   <= tx_active && (tx_state == S_IDLE);
      case (tx_state)
        S_START: out <= 1'b0;
        S_DATA:  out <= tx_shift[0];
        default: out <= 1'b1;
      endcase
      if (tx_state == S_IDLE) begin
        tx_cnt <= '0;
        tx_idx <= '0;
        if (pop_c) tx_shift <= mem[rd_ptr];
      end else if (tx_cnt == BIT_LAST) begin
        tx_cnt <= '0;
        if (tx_state == S_DATA) begin
          tx_idx   <= tx_idx + 3'd1;
          tx_shift <= {1'b0, tx_shift[7:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_responder.sv
// Bench for uart_echo_responder: drives 8N1 frames, decodes the echo line and
// compares against queue-based expectations derived from the link rules.
module tb_uart_echo_responder;

  localparam int unsigned CPB   = 16;
  localparam int unsigned FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst, in, tx_hold;
  logic       out, rx_valid, frame_err, overflow, tx_active, tx_done;
  logic [7:0] rx_byte;
  logic [2:0] fifo_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  uart_echo_responder #(.clocks_per_bit(CPB)) dut (
    .clk(clk), .rst(rst), .in(in), .tx_hold(tx_hold), .out(out),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .frame_err(frame_err),
    .overflow(overflow), .tx_active(tx_active), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation state filled by the monitors
  logic [7:0] rx_q[$];
  int         rxv_cyc_q[$];
  logic [7:0] out_q[$];
  int         out_fall_q[$];
  int         act_len_q[$];
  int fe_cnt, ov_cnt, ov_cyc, done_cnt, act_run, fifo_max;
  int both_cnt = 0, wide_cnt = 0, done_bad = 0, frame_shape_bad = 0;
  logic rxv_d = 1'b0, fe_d = 1'b0, ov_d = 1'b0;
  logic [7:0] last_good = 8'h00;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_q.push_back(rx_byte);
      rxv_cyc_q.push_back(cyc);
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (overflow === 1'b1) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (rx_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    if ((rx_valid === 1'b1 && rxv_d) || (frame_err === 1'b1 && fe_d) || (overflow === 1'b1 && ov_d))
      wide_cnt++;
    rxv_d = (rx_valid === 1'b1);
    fe_d  = (frame_err === 1'b1);
    ov_d  = (overflow === 1'b1);
    if (tx_done === 1'b1) begin
      done_cnt++;
      if (tx_active !== 1'b0) done_bad++;
    end
    if (tx_active === 1'b1) act_run++;
    else if (act_run != 0) begin
      act_len_q.push_back(act_run);
      act_run = 0;
    end
    if (int'(fifo_count) > fifo_max) fifo_max = int'(fifo_count);
  end

  // Serial decoder for the echo line; frames interrupted by reset are discarded
  logic [9:0] dec_bits;
  logic       dec_abort;
  int         dec_fall;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out === 1'b0) begin
        dec_fall  = cyc;
        dec_abort = 1'b0;
        dec_bits  = '0;
        for (int c = 0; c < int'(FRAME); c++) begin
          if (rst !== 1'b0) dec_abort = 1'b1;
          if (c % int'(CPB) == int'(CPB / 2)) dec_bits = {out, dec_bits[9:1]};
          @(negedge clk);
        end
        if (!dec_abort) begin
          out_q.push_back(dec_bits[8:1]);
          out_fall_q.push_back(dec_fall);
          if (dec_bits[0] !== 1'b0 || dec_bits[9] !== 1'b1) frame_shape_bad++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic clear_mon();
    rx_q.delete(); rxv_cyc_q.delete(); out_q.delete(); out_fall_q.delete(); act_len_q.delete();
    fe_cnt = 0; ov_cnt = 0; ov_cyc = -1; done_cnt = 0; act_run = 0; fifo_max = 0;
  endtask

  task automatic idle(input int n);
    in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame; abort_at > 0 pulses rst at that cycle of the frame
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_at, output int fall_cyc);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < int'(FRAME); i++) begin
      in = f[0];
      if (abort_at > 0 && i == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in  = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      if (i % int'(CPB) == int'(CPB) - 1) f = f >> 1;
    end
    if (stop) last_good = b;
  endtask

  task automatic wait_echo(input int n, input int budget);
    int t;
    t = 0;
    while (out_q.size() < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic test_reset();
    logic [16:0] got;
    rst = 1'b1; in = 1'b1; tx_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_mon();
    got = {out, tx_active, rx_valid, frame_err, overflow, tx_done, fifo_count, rx_byte};
    tests_run++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_values: got %h want %h", got, {1'b1, 16'h0000});
    end
    rst = 1'b0;
    idle(20);
    tests_run++;
    if (out !== 1'b1 || tx_active !== 1'b0 || fifo_count !== 3'd0 || rx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got out=%b act=%b cnt=%0d rx=%0d want 1 0 0 0",
               out, tx_active, fifo_count, rx_q.size());
    end
  endtask

  task automatic test_single_byte();
    int f, lat, echo_lat;
    logic [7:0] got;
    clear_mon();
    send_frame(8'h3F, 1'b1, 0, f);
    wait_echo(1, 400);
    idle(4);
    tests_run++;
    if (rx_q.size() != 1 || rx_byte !== 8'h3F) begin
      tests_failed++;
      $display("FAIL single_rx: got %0d pulses byte %h want 1 pulse byte 3f", rx_q.size(), rx_byte);
    end
    lat = (rxv_cyc_q.size() > 0) ? rxv_cyc_q[0] - (f + 1) : -1;
    tests_run++;
    if (lat < 152 || lat > 154) begin
      tests_failed++;
      $display("FAIL rx_latency: got %0d want 153+/-1", lat);
    end
    got = (out_q.size() > 0) ? out_q[0] : 8'hxx;
    tests_run++;
    if (out_q.size() != 1 || got !== 8'h3F) begin
      tests_failed++;
      $display("FAIL single_echo: got %0d frames first %h want 1 frame 3f", out_q.size(), got);
    end
    echo_lat = (out_fall_q.size() > 0 && rxv_cyc_q.size() > 0) ? out_fall_q[0] - rxv_cyc_q[0] : -1;
    tests_run++;
    if (echo_lat != 2) begin
      tests_failed++;
      $display("FAIL echo_latency: got %0d want 2", echo_lat);
    end
    tests_run++;
    if (done_cnt != 1 || act_len_q.size() != 1 || (act_len_q.size() > 0 && act_len_q[0] != int'(FRAME))) begin
      tests_failed++;
      $display("FAIL single_tx_frame: got done=%0d active_runs=%p want done=1 runs={160}", done_cnt, act_len_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    int f, bad;
    exp_q = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
    clear_mon();
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, 0, f);
    wait_echo(4, 600);
    idle(4);
    bad = 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    tests_run++;
    if (bad != 0 || rx_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_rx: got %p want %p", rx_q, exp_q);
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    tests_run++;
    if (bad != 0 || out_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_echo: got %p want %p", out_q, exp_q);
    end
    bad = 0;
    foreach (act_len_q[i]) if (act_len_q[i] != int'(FRAME)) bad++;
    tests_run++;
    if (bad != 0 || act_len_q.size() != 4 || done_cnt != 4) begin
      tests_failed++;
      $display("FAIL b2b_frames: got runs=%p done=%0d want four runs of 160 and done=4", act_len_q, done_cnt);
    end
    tests_run++;
    if (fifo_max > 1) begin
      tests_failed++;
      $display("FAIL b2b_fifo_peak: got %0d want <=1", fifo_max);
    end
  endtask

  task automatic test_frame_error();
    int f;
    logic [7:0] keep;
    keep = last_good;
    clear_mon();
    send_frame(8'h81, 1'b0, 0, f);
    idle(300);
    tests_run++;
    if (fe_cnt != 1) begin
      tests_failed++;
      $display("FAIL frame_err_pulse: got %0d want 1", fe_cnt);
    end
    tests_run++;
    if (rx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL frame_err_no_valid: got %0d rx_valid want 0", rx_q.size());
    end
    tests_run++;
    if (rx_byte !== keep) begin
      tests_failed++;
      $display("FAIL frame_err_rx_byte: got %h want %h", rx_byte, keep);
    end
    tests_run++;
    if (out_q.size() != 0 || act_len_q.size() != 0) begin
      tests_failed++;
      $display("FAIL frame_err_no_echo: got %0d frames want 0", out_q.size());
    end
  endtask

  task automatic test_glitch();
    int f;
    logic [7:0] got;
    clear_mon();
    in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(40);
    tests_run++;
    if (rx_q.size() != 0 || fe_cnt != 0 || ov_cnt != 0 || act_len_q.size() != 0) begin
      tests_failed++;
      $display("FAIL glitch_quiet: got rx=%0d fe=%0d ov=%0d tx=%0d want all 0",
               rx_q.size(), fe_cnt, ov_cnt, act_len_q.size());
    end
    send_frame(8'h96, 1'b1, 0, f);
    wait_echo(1, 400);
    idle(4);
    got = (out_q.size() > 0) ? out_q[0] : 8'hxx;
    tests_run++;
    if (rx_q.size() != 1 || rx_byte !== 8'h96 || got !== 8'h96) begin
      tests_failed++;
      $display("FAIL glitch_recover: got rx=%0d byte=%h echo=%h want 1 96 96", rx_q.size(), rx_byte, got);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] sent[$];
    logic [7:0] exp_q[$];
    int f, bad, want_ov;
    clear_mon();
    tx_hold = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      sent.push_back(8'(v));
      send_frame(8'(v), 1'b1, 0, f);
    end
    idle(20);
    // While held, only the first four bytes fit; the rest are dropped
    foreach (sent[i]) if (i < 4) exp_q.push_back(sent[i]);
    want_ov = sent.size() - exp_q.size();
    tests_run++;
    if (fifo_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL ovf_count: got %0d want 4", fifo_count);
    end
    tests_run++;
    if (ov_cnt != want_ov || rxv_cyc_q.size() != 5 || (rxv_cyc_q.size() == 5 && ov_cyc != rxv_cyc_q[4])) begin
      tests_failed++;
      $display("FAIL ovf_pulse: got %0d pulses at cycle %0d want %0d with 5th rx_valid", ov_cnt, ov_cyc, want_ov);
    end
    tests_run++;
    if (rx_byte !== 8'h05 || out_q.size() != 0) begin
      tests_failed++;
      $display("FAIL ovf_held: got byte=%h echoes=%0d want 05 and 0", rx_byte, out_q.size());
    end
    tx_hold = 1'b0;
    wait_echo(4, 900);
    idle(200);
    bad = 0;
    foreach (exp_q[i]) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    tests_run++;
    if (bad != 0 || out_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL ovf_echo: got %p want %p", out_q, exp_q);
    end
    tests_run++;
    if (fifo_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL ovf_drain: got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f;
    logic [7:0] got;
    clear_mon();
    send_frame(8'hC3, 1'b1, 0, f);
    // Reset lands mid-DATA for both the C3 echo and the next incoming byte
    send_frame(8'h55, 1'b1, 80, f);
    tests_run++;
    if (out !== 1'b1 || tx_active !== 1'b0 || fifo_count !== 3'd0 || rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got out=%b act=%b cnt=%0d want 1 0 0", out, tx_active, fifo_count);
    end
    idle(5);
    clear_mon();
    send_frame(8'h7E, 1'b1, 0, f);
    wait_echo(1, 400);
    idle(4);
    got = (out_q.size() > 0) ? out_q[0] : 8'hxx;
    tests_run++;
    if (rx_q.size() != 1 || out_q.size() != 1 || got !== 8'h7E || act_len_q.size() != 1) begin
      tests_failed++;
      $display("FAIL reset_recover: got rx=%0d echoes=%0d first=%h want 1 1 7e", rx_q.size(), out_q.size(), got);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic good;
    int f, bad, exp_fe;
    clear_mon();
    exp_fe = 0;
    for (int i = 0; i < 8; i++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_frame(b, good, 0, f);
      if (good) exp_q.push_back(b);
      else exp_fe++;
      idle(good ? int'($urandom_range(0, 12)) : 40 + int'($urandom_range(0, 10)));
    end
    wait_echo(exp_q.size(), 800);
    idle(4);
    bad = 0;
    foreach (exp_q[i]) if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    tests_run++;
    if (bad != 0 || rx_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_rx: got %p want %p", rx_q, exp_q);
    end
    bad = 0;
    foreach (exp_q[i]) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    tests_run++;
    if (bad != 0 || out_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_echo: got %p want %p", out_q, exp_q);
    end
    tests_run++;
    if (fe_cnt != exp_fe) begin
      tests_failed++;
      $display("FAIL rand_frame_err: got %0d want %0d", fe_cnt, exp_fe);
    end
    bad = 0;
    foreach (act_len_q[i]) if (act_len_q[i] != int'(FRAME)) bad++;
    tests_run++;
    if (bad != 0 || act_len_q.size() != exp_q.size() || done_cnt != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_frames: got runs=%p done=%0d want %0d runs of 160", act_len_q, done_cnt, exp_q.size());
    end
  endtask

  task automatic test_pulse_rules();
    tests_run++;
    if (both_cnt != 0) begin
      tests_failed++;
      $display("FAIL valid_and_err: got %0d overlaps want 0", both_cnt);
    end
    tests_run++;
    if (wide_cnt != 0 || done_bad != 0) begin
      tests_failed++;
      $display("FAIL pulse_width: got wide=%0d done_while_active=%0d want 0 0", wide_cnt, done_bad);
    end
    tests_run++;
    if (frame_shape_bad != 0) begin
      tests_failed++;
      $display("FAIL echo_framing: got %0d bad start/stop bits want 0", frame_shape_bad);
    end
  endtask

  initial begin
    rst = 1'b1; in = 1'b1; tx_hold = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    test_pulse_rules();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

Far-end UART responder for the 8N1 serial link driven by `Transmitter`. It receives serial bytes on its own oversampling receive path and buffers them in a 4-entry FIFO. It retransmits each byte unchanged on its serial output, so a `Transmitter`/`Receiver` pair can be looped through a real far-end peer instead of a wire. It is a standalone block with its own receive FSM, transmit FSM and buffer, and it shares only the link format and the `clocks_per_bit` convention.

## Interface
- `clocks_per_bit`, default 217: clk cycles per serial bit. Must be ≥ 4.
- `clk` input 1: sole clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in` input 1: serial receive line; idles high; asynchronous to `clk`.
- `tx_hold` input 1: when high, the TX FSM does not start a new frame; a frame already in progress completes.
- `out` output 1: serial transmit line; idles high.
- `rx_valid` output 1: one-cycle pulse when a frame with a good stop bit is received.
- `rx_byte` output 8: last good received byte; holds its value between pulses.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overflow` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `tx_active` output 1: high from the first start-bit cycle to the last stop-bit cycle.
- `tx_done` output 1: one-cycle pulse in the cycle after the last stop-bit cycle.
- `fifo_count` output 3: FIFO occupancy, 0..4.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
- `in` passes through a 2-flop synchronizer whose flops reset to 1. All RX decisions use the synchronized value `in_s`.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `in_s`==0, clear the counter and go to START.
  - START: count to (clocks_per_bit-1)/2 (integer division), then sample. If `in_s`==0, go to DATA. Otherwise go to IDLE as a glitch, with no output pulse.
  - DATA: every clocks_per_bit cycles, sample `in_s` into bit[i], for i = 0..7; after bit 7 go to STOP.
  - STOP: after clocks_per_bit cycles, sample. If 1: load `rx_byte`, pulse `rx_valid`, push to the FIFO. If 0: pulse `frame_err`; no push, `rx_byte` unchanged. In both cases go to IDLE.
- FIFO: depth 4, with 2-bit read/write pointers wrapping 3→0 and a separate 3-bit count.
  - Push when full: byte dropped, `overflow` pulses in the same cycle as `rx_valid`, FIFO unchanged.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This includes the full case: the pop frees the slot, so no overflow.
  - Pop when empty never occurs.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `out`=1. When `fifo_count`>0 and `tx_hold`==0, pop the head into the shift register and go to START.
  - START: `out`=0 for clocks_per_bit cycles.
  - DATA: `out`=bit[i] for clocks_per_bit cycles each, i = 0..7.
  - STOP: `out`=1 for clocks_per_bit cycles, then pulse `tx_done` and go to IDLE.
  - The next frame may start in the cycle following `tx_done`.
- `out` is driven from a register.
- Counter width: $clog2(clocks_per_bit).

## Timing
- Reset values: `out`=1, `tx_active`=0, `rx_valid`=0, `rx_byte`=0x00, `frame_err`=0, `overflow`=0, `tx_done`=0, `fifo_count`=0. Both FSMs return to IDLE and the synchronizer is set to 1.
- Reset mid-frame aborts both directions; `out` is high on the cycle after `rst` is sampled.
- RX latency: `rx_valid` asserts 2 + (clocks_per_bit-1)/2 + 9·clocks_per_bit cycles after the `in` falling edge, ±1 for synchronizer phase.
- Echo latency: with TX idle, FIFO empty and `tx_hold`=0, `out` falls 2 cycles after `rx_valid`:
  - cycle 1: push;
  - cycle 2: pop;
  - `out` registered low on the following edge.
- TX frame: `tx_active` is high for exactly 10·clocks_per_bit cycles. `tx_done` is one cycle wide and coincides with `tx_active`=0.
- `tx_hold` is sampled only in TX IDLE.
- `rx_valid`, `frame_err` and `overflow` are each exactly one cycle wide. `frame_err` and `rx_valid` are never high together.
- A start edge arriving in the cycle RX returns to IDLE is accepted.

## Test plan
All scenarios use clocks_per_bit=16 and a bench UART model.
- Single byte: send 0x3F → `rx_valid` with `rx_byte`=0x3F at the latency above. `out` carries frame 0x3F (bits 1,1,1,1,1,1,0,0 LSB first); `tx_done` pulses once.
- Back-to-back bytes: send 0xA5, 0x5A, 0x00, 0xFF with no idle gap → four `rx_valid` pulses. Echoed in the same order, each frame exactly 160 cycles; `fifo_count` never exceeds 1.
- Framing error: send 0x81 with the stop bit forced to 0 → `frame_err` pulse, no `rx_valid`, `rx_byte` unchanged, no echo on `out`.
- Glitch and overflow:
  - Glitch: `in` low for 3 cycles → no output pulses; RX returns to IDLE.
  - Overflow: with `tx_hold`=1, send 0x01..0x05 → `fifo_count` reaches 4 and `overflow` pulses on 0x05. Release `tx_hold` → echo of 0x01, 0x02, 0x03, 0x04 only.
- Reset mid-frame: assert `rst` during TX DATA of 0xC3 and during RX DATA → next cycle `out`=1, `tx_active`=0, `fifo_count`=0. A subsequent byte 0x7E echoes correctly.
